// File: rtl/shift_reg_tap_if.sv
// Signal bundle for the tapped shift register.
// The master drives the control and data inputs; the slave (the register)
// returns the selected tap word together with its fill qualifiers.
//
// Qualifier semantics: there is no ready/backpressure. data_in is captured
// on every rising clk edge where shift_en=1 and clear=0. data_out is
// meaningful only while out_valid=1; out_valid and data_out follow tap_sel
// combinationally within the same cycle.
interface shift_reg_tap_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 64
) ();
   localparam int TAP_W = $clog2(DEPTH);

   logic             shift_en;
   logic             clear;
   logic [TAP_W-1:0] tap_sel;
   logic [WIDTH-1:0] data_in;
   logic [WIDTH-1:0] data_out;
   logic             out_valid;
   logic             full;

   modport master (
      output shift_en,
      output clear,
      output tap_sel,
      output data_in,
      input  data_out,
      input  out_valid,
      input  full
   );

   modport slave (
      input  shift_en,
      input  clear,
      input  tap_sel,
      input  data_in,
      output data_out,
      output out_valid,
      output full
   );
endinterface

// File: rtl/shift_reg_tap.sv
// Configurable delay line: DEPTH stages of WIDTH bits with a runtime tap
// select, shift enable, synchronous clear and fill tracking so downstream
// logic can tell when the selected stage holds a real shifted-in word.
module shift_reg_tap #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 64
) (
   input logic            clk,
   input logic            rst_n,
   shift_reg_tap_if.slave bus
);
   // Tap index width is derived from DEPTH; the fill counter needs one more
   // bit so it can represent DEPTH itself.
   localparam int               TAP_W    = $clog2(DEPTH);
   localparam logic [TAP_W:0]   FILL_MAX = (TAP_W + 1)'(DEPTH);
   localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(DEPTH - 1);

   logic [WIDTH-1:0] r_stage [DEPTH];
   logic [TAP_W:0]   r_fill_cnt;
   logic [TAP_W-1:0] w_eff_tap;
   logic             w_full;
   logic             w_do_shift;

   // A shift happens only when clear is not asserted; clear always wins.
   assign w_do_shift = bus.shift_en && !bus.clear;
   assign w_full     = (r_fill_cnt == FILL_MAX);

   // Stage storage: clear zeroes everything, a shift moves each word one
   // stage deeper and the word leaving the last stage is dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_stage[i] <= '0;
         end
      end else if (bus.clear) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_stage[i] <= '0;
         end
      end else if (w_do_shift) begin
         r_stage[0] <= bus.data_in;
         for (int i = 1; i < DEPTH; i++) begin
            r_stage[i] <= r_stage[i-1];
         end
      end
   end

   // Fill counter: number of stages holding shifted-in data, saturating at
   // DEPTH so it never wraps once the line is full.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fill_cnt <= '0;
      end else if (bus.clear) begin
         r_fill_cnt <= '0;
      end else if (w_do_shift && !w_full) begin
         r_fill_cnt <= r_fill_cnt + 1'b1;
      end
   end

   // Tap clamp: a tap beyond the last stage reads the last stage. This only
   // bites when DEPTH is not a power of two.
   always_comb begin
      w_eff_tap = LAST_TAP;
      if ({1'b0, bus.tap_sel} < FILL_MAX) begin
         w_eff_tap = bus.tap_sel;
      end
   end

   // Outputs are purely combinational from registered state and the tap, so
   // a tap change is visible in the same cycle.
   assign bus.data_out  = r_stage[w_eff_tap];
   assign bus.out_valid = (r_fill_cnt > {1'b0, w_eff_tap});
   assign bus.full      = w_full;

endmodule

// File: tb/tb_shift_reg_tap.sv
// Self-checking bench for shift_reg_tap. Two instances (DEPTH=64 and a
// non-power-of-two DEPTH=48) receive identical stimulus; each is compared
// against a queue-based history model of the words shifted in.
module tb_shift_reg_tap;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   shift_reg_tap_if #(.WIDTH(8), .DEPTH(64)) bus_a ();
   shift_reg_tap_if #(.WIDTH(8), .DEPTH(48)) bus_b ();

   shift_reg_tap #(.WIDTH(8), .DEPTH(64)) dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_a)
   );

   shift_reg_tap #(.WIDTH(8), .DEPTH(48)) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_b)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // History of words shifted in, newest at index 0, truncated to the depth.
   // The word at stage k is simply the (k)th most recent word still held.
   logic [7:0] exp_q[$];
   logic [7:0] exp_q48[$];

   function automatic int eff_tap(input int depth, input int tap);
      return (tap < depth) ? tap : depth - 1;
   endfunction

   function automatic logic [7:0] exp_data_a(input int tap);
      int e;
      e = eff_tap(64, tap);
      return (e < exp_q.size()) ? exp_q[e] : 8'h00;
   endfunction

   function automatic logic [7:0] exp_data_b(input int tap);
      int e;
      e = eff_tap(48, tap);
      return (e < exp_q48.size()) ? exp_q48[e] : 8'h00;
   endfunction

   function automatic logic exp_valid_a(input int tap);
      return exp_q.size() > eff_tap(64, tap);
   endfunction

   function automatic logic exp_valid_b(input int tap);
      return exp_q48.size() > eff_tap(48, tap);
   endfunction

   function automatic logic exp_full_a();
      return exp_q.size() == 64;
   endfunction

   function automatic logic exp_full_b();
      return exp_q48.size() == 48;
   endfunction

   task automatic model_clear();
      exp_q.delete();
      exp_q48.delete();
   endtask

   task automatic model_step(input logic en, input logic clr, input logic [7:0] din);
      if (clr) begin
         model_clear();
      end else if (en) begin
         exp_q.push_front(din);
         if (exp_q.size() > 64) void'(exp_q.pop_back());
         exp_q48.push_front(din);
         if (exp_q48.size() > 48) void'(exp_q48.pop_back());
      end
   endtask

   // ---------------- drivers ----------------
   int cur_tap;

   task automatic set_tap(input int tap);
      cur_tap       = tap;
      bus_a.tap_sel = 6'(tap);
      bus_b.tap_sel = 6'(tap);
      #1;
   endtask

   // Present inputs, take one rising edge, then settle 1ns past it.
   task automatic drive(input logic en, input logic clr, input logic [7:0] din);
      bus_a.shift_en = en;  bus_b.shift_en = en;
      bus_a.clear    = clr; bus_b.clear    = clr;
      bus_a.data_in  = din; bus_b.data_in  = din;
      @(posedge clk);
      #1;
      model_step(en, clr, din);
      bus_a.shift_en = 1'b0; bus_b.shift_en = 1'b0;
      bus_a.clear    = 1'b0; bus_b.clear    = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      bus_a.shift_en = 1'b0; bus_b.shift_en = 1'b0;
      bus_a.clear    = 1'b0; bus_b.clear    = 1'b0;
      bus_a.data_in  = 8'h00; bus_b.data_in  = 8'h00;
      set_tap(0);
      model_clear();
      checks++; if (bus_a.data_out !== 8'h00) begin errors++; $display("FAIL reset_data_a got %h want 00", bus_a.data_out); end
      checks++; if (bus_a.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid_a got %b want 0", bus_a.out_valid); end
      checks++; if (bus_a.full !== 1'b0) begin errors++; $display("FAIL reset_full_a got %b want 0", bus_a.full); end
      checks++; if (bus_b.data_out !== 8'h00) begin errors++; $display("FAIL reset_data_b got %h want 00", bus_b.data_out); end
      checks++; if (bus_b.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid_b got %b want 0", bus_b.out_valid); end
      // shift_en while in reset must not capture anything
      bus_a.shift_en = 1'b1; bus_b.shift_en = 1'b1;
      bus_a.data_in  = 8'h5A; bus_b.data_in  = 8'h5A;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (bus_a.out_valid !== 1'b0 || bus_a.data_out !== 8'h00) begin errors++; $display("FAIL reset_hold_a got %b/%h want 0/00", bus_a.out_valid, bus_a.data_out); end
      bus_a.shift_en = 1'b0; bus_b.shift_en = 1'b0;
      rst_n = 1'b1;
   endtask

   task automatic test_delay();
      set_tap(0);
      drive(1'b1, 1'b0, 8'h11);
      checks++; if (bus_a.data_out !== 8'h11) begin errors++; $display("FAIL delay_e1_data got %h want 11", bus_a.data_out); end
      checks++; if (bus_a.out_valid !== 1'b1) begin errors++; $display("FAIL delay_e1_valid got %b want 1", bus_a.out_valid); end
      drive(1'b1, 1'b0, 8'h22);
      checks++; if (bus_a.data_out !== 8'h22) begin errors++; $display("FAIL delay_e2_data got %h want 22", bus_a.data_out); end
      checks++; if (bus_a.full !== 1'b0) begin errors++; $display("FAIL delay_e2_full got %b want 0", bus_a.full); end
      checks++; if (bus_b.data_out !== exp_data_b(cur_tap)) begin errors++; $display("FAIL delay_e2_data_b got %h want %h", bus_b.data_out, exp_data_b(cur_tap)); end
   endtask

   task automatic test_full_depth();
      drive(1'b0, 1'b1, 8'h00);
      set_tap(63);
      for (int e = 1; e <= 65; e++) begin
         drive(1'b1, 1'b0, 8'(e - 1));
         checks++; if (bus_a.data_out !== exp_data_a(cur_tap)) begin errors++; $display("FAIL full_data_a e%0d got %h want %h", e, bus_a.data_out, exp_data_a(cur_tap)); end
         checks++; if (bus_a.out_valid !== exp_valid_a(cur_tap)) begin errors++; $display("FAIL full_valid_a e%0d got %b want %b", e, bus_a.out_valid, exp_valid_a(cur_tap)); end
         checks++; if (bus_a.full !== exp_full_a()) begin errors++; $display("FAIL full_full_a e%0d got %b want %b", e, bus_a.full, exp_full_a()); end
         checks++; if (bus_b.data_out !== exp_data_b(cur_tap) || bus_b.out_valid !== exp_valid_b(cur_tap)) begin errors++; $display("FAIL full_b e%0d got %h/%b want %h/%b", e, bus_b.data_out, bus_b.out_valid, exp_data_b(cur_tap), exp_valid_b(cur_tap)); end
         if (e == 63) begin
            checks++; if (bus_a.out_valid !== 1'b0) begin errors++; $display("FAIL full_e63_valid got %b want 0", bus_a.out_valid); end
         end
         if (e == 64) begin
            checks++; if (bus_a.out_valid !== 1'b1 || bus_a.data_out !== 8'h00 || bus_a.full !== 1'b1) begin errors++; $display("FAIL full_e64 got %b/%h/%b want 1/00/1", bus_a.out_valid, bus_a.data_out, bus_a.full); end
         end
         if (e == 65) begin
            checks++; if (bus_a.data_out !== 8'h01) begin errors++; $display("FAIL full_e65_data got %h want 01", bus_a.data_out); end
         end
      end
   endtask

   task automatic test_gaps();
      drive(1'b0, 1'b1, 8'h00);
      set_tap(3);
      drive(1'b1, 1'b0, 8'hA5);
      for (int c = 0; c < 5; c++) begin
         drive(1'b0, 1'b0, 8'($urandom));
         checks++; if (bus_a.out_valid !== 1'b0 || bus_a.data_out !== 8'h00) begin errors++; $display("FAIL gap_idle c%0d got %b/%h want 0/00", c, bus_a.out_valid, bus_a.data_out); end
      end
      for (int s = 2; s <= 4; s++) begin
         drive(1'b1, 1'b0, 8'($urandom_range(0, 8'h7F)));
         checks++; if (bus_a.data_out !== exp_data_a(cur_tap) || bus_a.out_valid !== exp_valid_a(cur_tap)) begin errors++; $display("FAIL gap_shift s%0d got %h/%b want %h/%b", s, bus_a.data_out, bus_a.out_valid, exp_data_a(cur_tap), exp_valid_a(cur_tap)); end
      end
      checks++; if (bus_a.data_out !== 8'hA5 || bus_a.out_valid !== 1'b1) begin errors++; $display("FAIL gap_arrive got %h/%b want a5/1", bus_a.data_out, bus_a.out_valid); end
      for (int c = 0; c < 3; c++) begin
         drive(1'b0, 1'b0, 8'($urandom));
         checks++; if (bus_a.data_out !== 8'hA5) begin errors++; $display("FAIL gap_hold c%0d got %h want a5", c, bus_a.data_out); end
      end
   endtask

   task automatic test_clear_priority();
      for (int i = 0; i < 66; i++) drive(1'b1, 1'b0, 8'($urandom));
      checks++; if (bus_a.full !== 1'b1) begin errors++; $display("FAIL clr_prefull got %b want 1", bus_a.full); end
      set_tap(10);
      drive(1'b1, 1'b1, 8'hEE);
      checks++; if (bus_a.data_out !== 8'h00 || bus_a.out_valid !== 1'b0 || bus_a.full !== 1'b0) begin errors++; $display("FAIL clr_outputs got %h/%b/%b want 00/0/0", bus_a.data_out, bus_a.out_valid, bus_a.full); end
      checks++; if (bus_b.full !== 1'b0 || bus_b.out_valid !== 1'b0) begin errors++; $display("FAIL clr_outputs_b got %b/%b want 0/0", bus_b.full, bus_b.out_valid); end
      for (int t = 0; t < 64; t += 9) begin
         set_tap(t);
         checks++; if (bus_a.data_out !== 8'h00 || bus_a.out_valid !== 1'b0) begin errors++; $display("FAIL clr_stage t%0d got %h/%b want 00/0", t, bus_a.data_out, bus_a.out_valid); end
         drive(1'b0, 1'b0, 8'h00);
      end
   endtask

   task automatic test_tap_change();
      logic [7:0] first;
      drive(1'b0, 1'b1, 8'h00);
      set_tap(20);
      first = 8'($urandom);
      drive(1'b1, 1'b0, first);
      for (int i = 1; i < 10; i++) drive(1'b1, 1'b0, 8'($urandom));
      checks++; if (bus_a.out_valid !== 1'b0) begin errors++; $display("FAIL tap20_valid got %b want 0", bus_a.out_valid); end
      set_tap(9);
      checks++; if (bus_a.out_valid !== 1'b1) begin errors++; $display("FAIL tap9_valid got %b want 1", bus_a.out_valid); end
      checks++; if (bus_a.data_out !== first) begin errors++; $display("FAIL tap9_data got %h want %h", bus_a.data_out, first); end
      checks++; if (bus_b.data_out !== exp_data_b(cur_tap) || bus_b.out_valid !== 1'b1) begin errors++; $display("FAIL tap9_b got %h/%b want %h/1", bus_b.data_out, bus_b.out_valid, exp_data_b(cur_tap)); end
      set_tap(2);
      checks++; if (bus_a.out_valid !== 1'b1 || bus_a.data_out !== exp_data_a(cur_tap)) begin errors++; $display("FAIL tap2 got %b/%h want 1/%h", bus_a.out_valid, bus_a.data_out, exp_data_a(cur_tap)); end
   endtask

   task automatic test_clamp();
      logic [7:0] oldest;
      drive(1'b0, 1'b1, 8'h00);
      set_tap(60);
      for (int i = 1; i <= 50; i++) begin
         drive(1'b1, 1'b0, 8'($urandom));
         if (i == 47) begin
            checks++; if (bus_b.out_valid !== 1'b0) begin errors++; $display("FAIL clamp_e47_valid got %b want 0", bus_b.out_valid); end
         end
         if (i == 48) begin
            checks++; if (bus_b.out_valid !== 1'b1 || bus_b.full !== 1'b1) begin errors++; $display("FAIL clamp_e48 got %b/%b want 1/1", bus_b.out_valid, bus_b.full); end
         end
      end
      // After 50 shifts into 48 stages the last stage holds the 3rd word.
      oldest = exp_q48[47];
      checks++; if (bus_b.data_out !== oldest) begin errors++; $display("FAIL clamp_data got %h want %h", bus_b.data_out, oldest); end
      checks++; if (bus_a.data_out !== exp_data_a(cur_tap) || bus_a.out_valid !== 1'b0) begin errors++; $display("FAIL clamp_a got %h/%b want %h/0", bus_a.data_out, bus_a.out_valid, exp_data_a(cur_tap)); end
      for (int t = 48; t < 64; t += 5) begin
         set_tap(t);
         checks++; if (bus_b.data_out !== oldest) begin errors++; $display("FAIL clamp_t%0d got %h want %h", t, bus_b.data_out, oldest); end
      end
      drive(1'b0, 1'b0, 8'h00);
   endtask

   task automatic test_random();
      logic en, clr;
      for (int c = 0; c < 400; c++) begin
         en  = ($urandom_range(0, 3) != 0);
         clr = ($urandom_range(0, 59) == 0);
         drive(en, clr, 8'($urandom));
         checks++; if (bus_a.data_out !== exp_data_a(cur_tap) || bus_a.out_valid !== exp_valid_a(cur_tap) || bus_a.full !== exp_full_a()) begin errors++; $display("FAIL rand_a c%0d tap%0d got %h/%b/%b want %h/%b/%b", c, cur_tap, bus_a.data_out, bus_a.out_valid, bus_a.full, exp_data_a(cur_tap), exp_valid_a(cur_tap), exp_full_a()); end
         checks++; if (bus_b.data_out !== exp_data_b(cur_tap) || bus_b.out_valid !== exp_valid_b(cur_tap) || bus_b.full !== exp_full_b()) begin errors++; $display("FAIL rand_b c%0d tap%0d got %h/%b/%b want %h/%b/%b", c, cur_tap, bus_b.data_out, bus_b.out_valid, bus_b.full, exp_data_b(cur_tap), exp_valid_b(cur_tap), exp_full_b()); end
         if ($urandom_range(0, 3) == 0) begin
            set_tap($urandom_range(0, 63));
            checks++; if (bus_a.data_out !== exp_data_a(cur_tap) || bus_a.out_valid !== exp_valid_a(cur_tap)) begin errors++; $display("FAIL rand_tap_a c%0d tap%0d got %h/%b want %h/%b", c, cur_tap, bus_a.data_out, bus_a.out_valid, exp_data_a(cur_tap), exp_valid_a(cur_tap)); end
            checks++; if (bus_b.data_out !== exp_data_b(cur_tap) || bus_b.out_valid !== exp_valid_b(cur_tap)) begin errors++; $display("FAIL rand_tap_b c%0d tap%0d got %h/%b want %h/%b", c, cur_tap, bus_b.data_out, bus_b.out_valid, exp_data_b(cur_tap), exp_valid_b(cur_tap)); end
         end
      end
   endtask

   task automatic test_async_reset();
      set_tap(5);
      for (int i = 0; i < 70; i++) drive(1'b1, 1'b0, 8'($urandom_range(1, 255)));
      checks++; if (bus_a.full !== 1'b1 || bus_a.out_valid !== 1'b1) begin errors++; $display("FAIL areset_pre got %b/%b want 1/1", bus_a.full, bus_a.out_valid); end
      // Mid-cycle: 3ns after the edge, well before the next one.
      #2;
      rst_n = 1'b0;
      #1;
      model_clear();
      checks++; if (bus_a.data_out !== 8'h00 || bus_a.out_valid !== 1'b0 || bus_a.full !== 1'b0) begin errors++; $display("FAIL areset_a got %h/%b/%b want 00/0/0", bus_a.data_out, bus_a.out_valid, bus_a.full); end
      checks++; if (bus_b.data_out !== 8'h00 || bus_b.out_valid !== 1'b0 || bus_b.full !== 1'b0) begin errors++; $display("FAIL areset_b got %h/%b/%b want 00/0/0", bus_b.data_out, bus_b.out_valid, bus_b.full); end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      set_tap(0);
      drive(1'b1, 1'b0, 8'h3C);
      checks++; if (bus_a.data_out !== 8'h3C || bus_a.out_valid !== 1'b1 || bus_a.full !== 1'b0) begin errors++; $display("FAIL areset_restart got %h/%b/%b want 3c/1/0", bus_a.data_out, bus_a.out_valid, bus_a.full); end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      checks  = 0;
      errors  = 0;
      cur_tap = 0;
      test_reset();
      test_delay();
      test_full_depth();
      test_gaps();
      test_clear_priority();
      test_tap_change();
      test_clamp();
      test_random();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
